pc_fetch_sequencer: RTL and testbench

//  Owns the program counter (PC), instruction register (IR) and 2-bit microstate register.

---
 rtl/cpu_defs_pkg.sv | 28 ++
 rtl/pc_next_calc.sv | 31 +++
 rtl/pc_fetch_sequencer.sv | 101 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch sequencer and the per-opcode control decoders.
package cpu_defs_pkg;

   // PC update selects carried in the decoder controlword
   localparam logic [1:0] PSEL_HOLD = 2'b00;
   localparam logic [1:0] PSEL_INC  = 2'b01;
   localparam logic [1:0] PSEL_ABS  = 2'b10;
   localparam logic [1:0] PSEL_REL  = 2'b11;

   // One-hot so each phase is a single flop bit and the phase outputs need no decode
   typedef enum logic [2:0] {
      FETCH_REQ  = 3'b001,
      FETCH_WAIT = 3'b010,
      EXEC       = 3'b100
   } fetch_state_t;

   // Controlword layout: sequencing fields in the low bits, datapath-owned fields above
   localparam int CW_W              = 31;
   localparam int CW_PSEL_LSB       = 0;
   localparam int CW_PSEL_W         = 2;
   localparam int CW_PCSEL_BIT      = 2;
   localparam int CW_NEXT_STATE_LSB = 3;
   localparam int CW_NEXT_STATE_W   = 2;
   localparam int CW_EN_PC_BIT      = 5;
   localparam int CW_DP_LSB         = 6;
   localparam int CW_DP_W           = CW_W - CW_DP_LSB;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold, sequential, absolute target or word-relative branch.
module pc_next_calc
   import cpu_defs_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic                   [PC_W-1:0] pc,
   input  logic                   [1:0]      psel,
   input  logic                              pcsel,
   input  logic signed            [PC_W-1:0] k,
   input  logic                   [PC_W-1:0] a_bus,
   output logic                   [PC_W-1:0] pc_nxt
);

   logic        [PC_W-1:0] target;
   logic signed [PC_W-1:0] offset;

   // Select the next PC; all sums wrap modulo 2^PC_W and targets are forced word-aligned
   always_comb begin
      target = pcsel ? k : a_bus;
      offset = k <<< 2;
      pc_nxt = pc;
      case (psel)
         PSEL_HOLD: pc_nxt = pc;
         PSEL_INC:  pc_nxt = pc + PC_W'(4);
         PSEL_ABS:  pc_nxt = {target[PC_W-1:2], 2'b00};
         PSEL_REL:  pc_nxt = pc + $unsigned(offset);
      endcase
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter, instruction register and microstate owner. Fetches one instruction
// per req/valid handshake, then lets the control decoders run one or more EXEC cycles.
module pc_fetch_sequencer
   import cpu_defs_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic        [1:0]      psel,
   input  logic                   pcsel,
   input  logic        [1:0]      next_state,
   input  logic                   en_pc,
   input  logic signed [PC_W-1:0] k,
   input  logic        [PC_W-1:0] a_bus,
   input  logic        [31:0]     imem_rdata,
   input  logic                   imem_valid,
   output logic                   imem_req,
   output logic        [PC_W-1:0] imem_addr,
   output logic        [31:0]     instruction,
   output logic        [1:0]      state,
   output logic        [PC_W-1:0] pc,
   output logic        [PC_W-1:0] pc_bus,
   output logic                   exec_valid,
   output logic                   fetch_err
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   fetch_state_t      fsm;
   logic [WAIT_W-1:0] wait_cnt;
   logic [PC_W-1:0]   pc_nxt;

   pc_next_calc #(
      .PC_W (PC_W)
   ) u_pc_next_calc (
      .pc     (pc),
      .psel   (psel),
      .pcsel  (pcsel),
      .k      (k),
      .a_bus  (a_bus),
      .pc_nxt (pc_nxt)
   );

   // Phase outputs come straight off the one-hot state flops; the request is held low while
   // reset is asserted so nothing is issued from the reset cycle itself
   assign imem_req   = (fsm == FETCH_REQ) && !reset;
   assign exec_valid = (fsm == EXEC);
   assign imem_addr  = pc;

   // Link value is the return address of the executing instruction, driven only on request
   assign pc_bus = en_pc ? (pc + PC_W'(4)) : '0;

   // Fetch/execute sequencing with PC, IR, microstate, timeout counter and sticky error
   always_ff @(posedge clock) begin
      if (reset) begin
         fsm         <= FETCH_REQ;
         pc          <= RESET_PC;
         instruction <= '0;
         state       <= 2'b00;
         fetch_err   <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (fsm)
            FETCH_REQ: begin
               wait_cnt <= '0;
               fsm      <= FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (imem_valid) begin
                  instruction <= imem_rdata;
                  state       <= 2'b00;
                  wait_cnt    <= '0;
                  fsm         <= EXEC;
               end else if (wait_cnt == WAIT_LAST) begin
                  // Give up on this response and re-issue the same address
                  fetch_err <= 1'b1;
                  wait_cnt  <= '0;
                  fsm       <= FETCH_REQ;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            EXEC: begin
               if (next_state != 2'b00) begin
                  state <= next_state;
               end else begin
                  pc    <= pc_nxt;
                  state <= 2'b00;
                  fsm   <= FETCH_REQ;
               end
            end
            default: fsm <= FETCH_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: cycle-level reference model compared every cycle, a table of
// PC-update vectors, hand sequences for multi-cycle corners, then randomized instructions.
module tb_pc_fetch_sequencer;

   localparam int          PC_W     = 64;
   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          MAX_WAIT = 255;

   logic               clock = 1'b0;
   logic               reset;
   logic        [1:0]  psel;
   logic               pcsel;
   logic        [1:0]  next_state;
   logic               en_pc;
   logic signed [63:0] k;
   logic        [63:0] a_bus;
   logic        [31:0] imem_rdata;
   logic               imem_valid;
   logic               imem_req;
   logic        [63:0] imem_addr;
   logic        [31:0] instruction;
   logic        [1:0]  state;
   logic        [63:0] pc;
   logic        [63:0] pc_bus;
   logic               exec_valid;
   logic               fetch_err;

   pc_fetch_sequencer #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .psel        (psel),
      .pcsel       (pcsel),
      .next_state  (next_state),
      .en_pc       (en_pc),
      .k           (k),
      .a_bus       (a_bus),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .instruction (instruction),
      .state       (state),
      .pc          (pc),
      .pc_bus      (pc_bus),
      .exec_valid  (exec_valid),
      .fetch_err   (fetch_err)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase 0=request, 1=waiting for memory, 2=executing
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic [1:0]  m_st;
   int          m_phase;
   int          m_wait;
   bit          m_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_next(input logic [63:0] cur, input logic [1:0] sel,
                                            input logic ps, input logic [63:0] kk,
                                            input logic [63:0] aa);
      logic [63:0] t;
      case (sel)
         2'd0:    return cur;
         2'd1:    return cur + 64'd4;
         2'd2:    begin t = ps ? kk : aa; return t - (t % 64'd4); end
         default: return cur + kk * 64'd4;
      endcase
   endfunction

   task automatic model_step();
      if (reset) begin
         m_pc = RESET_PC; m_ir = '0; m_st = 2'b00; m_phase = 0; m_wait = 0; m_err = 1'b0;
      end else if (m_phase == 0) begin
         m_phase = 1; m_wait = 0;
      end else if (m_phase == 1) begin
         if (imem_valid) begin
            m_ir = imem_rdata; m_st = 2'b00; m_phase = 2; m_wait = 0;
         end else begin
            m_wait++;
            if (m_wait >= MAX_WAIT) begin
               m_err = 1'b1; m_wait = 0; m_phase = 0;
            end
         end
      end else begin
         if (next_state != 2'b00) m_st = next_state;
         else begin
            m_pc = ref_next(m_pc, psel, pcsel, k, a_bus); m_st = 2'b00; m_phase = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("imem_req",    imem_req,    (m_phase == 0) && !reset);
      chk("imem_addr",   imem_addr,   m_pc);
      chk("instruction", instruction, m_ir);
      chk("state",       state,       m_st);
      chk("pc",          pc,          m_pc);
      chk("pc_bus",      pc_bus,      en_pc ? m_pc + 64'd4 : 64'd0);
      chk("exec_valid",  exec_valid,  m_phase == 2);
      chk("fetch_err",   fetch_err,   m_err);
   endtask

   // Called at posedge+1 with inputs already driven; compares mid-cycle, advances to posedge+1
   task automatic cyc();
      #4;
      compare_all();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      psel = 2'b00; pcsel = 1'b0; next_state = 2'b00; en_pc = 1'b0;
      k = '0; a_bus = '0; imem_rdata = '0; imem_valid = 1'b0;
   endtask

   task automatic fetch(input int delay, input logic [31:0] word);
      cyc();
      for (int i = 0; i < delay; i++) cyc();
      imem_valid = 1'b1; imem_rdata = word;
      cyc();
      imem_valid = 1'b0; imem_rdata = '0;
   endtask

   task automatic exec_op(input logic [1:0] ns, input logic [1:0] ps, input logic pcs,
                          input logic [63:0] kk, input logic [63:0] aa, input logic en,
                          input logic stray);
      next_state = ns; psel = ps; pcsel = pcs; k = kk; a_bus = aa; en_pc = en;
      if (stray) begin imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      cyc();
      idle();
   endtask

   task automatic run_instr(input int delay, input logic [31:0] word, input logic [1:0] ps,
                            input logic pcs, input logic [63:0] kk, input logic [63:0] aa,
                            input logic en);
      fetch(delay, word);
      exec_op(2'b00, ps, pcs, kk, aa, en, 1'b0);
   endtask

   typedef struct {
      logic [63:0] start;
      logic [1:0]  ps;
      logic        pcs;
      logic [63:0] kk;
      logic [63:0] aa;
      logic [63:0] exp_pc;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [63:0] saved;
      tbl[0] = '{64'h40,                   2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,    64'h30};
      tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFC,  2'b01, 1'b0, 64'h0,                   64'h0,    64'h0};
      tbl[2] = '{64'h100,                  2'b10, 1'b0, 64'h0,                   64'h1003, 64'h1000};
      tbl[3] = '{64'h100,                  2'b10, 1'b1, 64'h2_0007,              64'h55,   64'h2_0004};
      tbl[4] = '{64'h200,                  2'b00, 1'b0, 64'h77,                  64'h99,   64'h200};
      tbl[5] = '{64'h0,                    2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC};
      tbl[6] = '{64'h8,                    2'b11, 1'b0, 64'h3,                   64'h0,    64'h14};

      idle();
      reset = 1'b1;
      @(posedge clock); #1;
      model_step();
      cyc();
      reset = 1'b0;

      // Sequential fetch with immediate response
      chk("t1_pc0", pc, 64'h0);
      run_instr(0, 32'h1111_0001, 2'b01, 1'b0, '0, '0, 1'b0);
      chk("t1_pc1", pc, 64'h4);
      fetch(0, 32'h1111_0002);
      chk("t1_ir", instruction, 64'h1111_0002);
      exec_op(2'b00, 2'b01, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t1_pc2", pc, 64'h8);
      chk("t1_req", imem_req, 1'b1);

      // BR through register A with misaligned target
      run_instr(0, 32'h2222_0000, 2'b10, 1'b0, '0, 64'h1003, 1'b0);
      chk("t2_addr", imem_addr, 64'h1000);

      // PC update vectors
      foreach (tbl[i]) begin
         run_instr(0, 32'h3000_0000 + i, 2'b10, 1'b0, '0, tbl[i].start, 1'b0);
         chk("tbl_start", pc, tbl[i].start);
         run_instr(1, 32'h3100_0000 + i, tbl[i].ps, tbl[i].pcs, tbl[i].kk, tbl[i].aa, 1'b1);
         chk("tbl_pc", pc, tbl[i].exp_pc);
      end

      // Multi-cycle op: PC must not move until the final EXEC cycle
      run_instr(0, 32'h4000_0000, 2'b10, 1'b0, '0, 64'h500, 1'b0);
      fetch(0, 32'h4000_0001);
      exec_op(2'b01, 2'b01, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t4_state1", state, 2'b01);
      chk("t4_hold1", pc, 64'h500);
      exec_op(2'b10, 2'b01, 1'b0, '0, '0, 1'b0, 1'b1);
      chk("t4_state2", state, 2'b10);
      chk("t4_hold2", pc, 64'h500);
      chk("t4_ir", instruction, 64'h4000_0001);
      exec_op(2'b00, 2'b01, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("t4_pc", pc, 64'h504);
      chk("t4_state0", state, 2'b00);
      chk("t4_req", imem_req, 1'b1);

      // Timeout: no response at all
      saved = pc;
      cyc();
      for (int i = 0; i < MAX_WAIT; i++) begin
         if (i == MAX_WAIT - 1) chk("t5_err_early", fetch_err, 1'b0);
         cyc();
      end
      chk("t5_err", fetch_err, 1'b1);
      chk("t5_req_again", imem_req, 1'b1);
      chk("t5_addr_again", imem_addr, saved);
      // Response on the last allowed wait cycle is still accepted
      cyc();
      for (int i = 0; i < MAX_WAIT - 1; i++) cyc();
      imem_valid = 1'b1; imem_rdata = 32'h5555_AAAA;
      cyc();
      imem_valid = 1'b0;
      chk("t5_late_exec", exec_valid, 1'b1);
      chk("t5_sticky", fetch_err, 1'b1);
      exec_op(2'b00, 2'b01, 1'b0, '0, '0, 1'b0, 1'b0);
      // Reset in the middle of a wait
      cyc();
      for (int i = 0; i < 5; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("t5_rst_pc", pc, RESET_PC);
      chk("t5_rst_err", fetch_err, 1'b0);

      // Link value and stray response during EXEC
      run_instr(0, 32'h6000_0000, 2'b10, 1'b0, '0, 64'h20, 1'b0);
      fetch(2, 32'h6000_0001);
      en_pc = 1'b1; #1;
      chk("t6_pcbus", pc_bus, 64'h24);
      en_pc = 1'b0; #1;
      chk("t6_pcbus_off", pc_bus, 64'h0);
      exec_op(2'b00, 2'b00, 1'b0, '0, '0, 1'b1, 1'b1);
      chk("t6_ir_kept", instruction, 64'h6000_0001);

      // Randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         int steps;
         if (n % 5 == 0) begin imem_valid = 1'b1; imem_rdata = $urandom; end
         fetch($urandom_range(0, 3), $urandom);
         steps = $urandom_range(0, 2);
         for (int s = 0; s < steps; s++)
            exec_op(2'($urandom_range(1, 3)), 2'($urandom), 1'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
         exec_op(2'b00, 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($signed(8'($urandom))),
                 {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
